// File: rtl/silvland_pkg.sv
// Shared types and default constants for the Silver Land ROM download path.
// Imported by dl_slot_div and silvland_dl_ctrl.
package silvland_pkg;

   typedef enum logic [2:0] {
      EMPTY,
      LOAD,
      FLUSH,
      HOLD,
      RUN
   } dl_state_t;

   localparam logic [16:0] DEF_EXP_BYTES   = 17'h0C000;
   localparam int          DEF_HOLD_CYCLES = 1024;
   localparam int          DEF_WR_DIV      = 4;

endpackage

// File: rtl/dl_slot_div.sv
// Free-running write-slot divider: slot is high when the counter is 0,
// slot_pre is high the cycle before. Ports: clk_sys, reset in; slot,
// slot_pre out. WR_DIV must be a power of two (2..16).
module dl_slot_div
   import silvland_pkg::*;
#(
   parameter int WR_DIV = DEF_WR_DIV
) (
   input  logic clk_sys,
   input  logic reset,
   output logic slot,
   output logic slot_pre
);

   localparam int CW = (WR_DIV > 1) ? $clog2(WR_DIV) : 1;

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Power-of-two period, so natural wrap gives the modulo.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign slot     = (cnt_q == '0);
   assign slot_pre = (cnt_q == CW'(WR_DIV - 1));

endmodule

// File: rtl/silvland_dl_ctrl.sv
// ROM download controller: one-entry write buffer paced onto dn_* by the
// slot divider, ioctl_wait back-pressure, core reset hold and status.
// Ports: clk_sys/reset, ioctl_* download in, ioctl_wait out, dn_* ROM
// write out, core_reset, dl_done, dl_err, dl_sum status out.
module silvland_dl_ctrl
   import silvland_pkg::*;
#(
   parameter logic [16:0] EXP_BYTES   = DEF_EXP_BYTES,
   parameter int          HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int          WR_DIV      = DEF_WR_DIV
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [15:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic        core_reset,
   output logic        dl_done,
   output logic        dl_err,
   output logic [7:0]  dl_sum
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);

   dl_state_t   state_q, state_d;
   logic        buf_full_q, buf_full_d;
   logic [15:0] buf_addr_q, buf_addr_d;
   logic [7:0]  buf_data_q, buf_data_d;
   logic [16:0] byte_cnt_q, byte_cnt_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic        wait_q, wait_d;
   logic        dn_wr_q, dn_wr_d;
   logic [15:0] dn_addr_q, dn_addr_d;
   logic [7:0]  dn_data_q, dn_data_d;
   logic        core_reset_q, core_reset_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [7:0]  sum_q, sum_d;

   logic slot;
   logic slot_pre;
   logic drain;
   logic in_load;
   logic addr_ok;
   logic accept;

   dl_slot_div #(
      .WR_DIV (WR_DIV)
   ) u_slot (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .slot     (slot),
      .slot_pre (slot_pre)
   );

   assign drain   = slot & buf_full_q;
   assign in_load = (state_q == LOAD);
   assign addr_ok = (ioctl_addr[24:16] == 9'd0);
   // A draining slot frees the entry in the same cycle it is refilled.
   assign accept  = in_load & ioctl_wr & addr_ok & (~buf_full_q | drain);

   always_comb begin
      state_d    = state_q;
      buf_addr_d = buf_addr_q;
      buf_data_d = buf_data_q;
      byte_cnt_d = byte_cnt_q;
      hold_cnt_d = hold_cnt_q;
      err_d      = err_q;
      sum_d      = sum_q;
      dn_addr_d  = dn_addr_q;
      dn_data_d  = dn_data_q;

      buf_full_d = accept | (buf_full_q & ~drain);

      if (accept) begin
         buf_addr_d = ioctl_addr[15:0];
         buf_data_d = ioctl_dout;
         sum_d      = sum_q + ioctl_dout;
         if (byte_cnt_q != '1) begin
            byte_cnt_d = byte_cnt_q + 17'd1;
         end
      end

      if (in_load & ioctl_wr & (~addr_ok | (buf_full_q & ~drain))) begin
         err_d = 1'b1;
      end

      unique case (state_q)
         EMPTY: begin
            if (ioctl_download) state_d = LOAD;
         end
         LOAD: begin
            if (!ioctl_download) state_d = FLUSH;
         end
         FLUSH: begin
            // Leave on the draining cycle so the hold starts right after it.
            if (!buf_full_d) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
               if (byte_cnt_q != EXP_BYTES) err_d = 1'b1;
            end
         end
         HOLD: begin
            if (ioctl_download) begin
               state_d = LOAD;
            end else if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         RUN: begin
            if (ioctl_download) state_d = LOAD;
         end
         default: state_d = EMPTY;
      endcase

      if ((state_d == LOAD) && (state_q != LOAD)) begin
         sum_d      = '0;
         byte_cnt_d = '0;
         err_d      = 1'b0;
      end

      // Outputs are registered one cycle ahead so dn_wr lands on the slot.
      wait_d  = buf_full_d;
      dn_wr_d = slot_pre & buf_full_d;
      if (dn_wr_d) begin
         dn_addr_d = buf_addr_d;
         dn_data_d = buf_data_d;
      end
      core_reset_d = (state_d != RUN);
      done_d       = (state_d == RUN);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= EMPTY;
         buf_full_q   <= 1'b0;
         buf_addr_q   <= '0;
         buf_data_q   <= '0;
         byte_cnt_q   <= '0;
         hold_cnt_q   <= '0;
         wait_q       <= 1'b0;
         dn_wr_q      <= 1'b0;
         dn_addr_q    <= '0;
         dn_data_q    <= '0;
         core_reset_q <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         sum_q        <= '0;
      end else begin
         state_q      <= state_d;
         buf_full_q   <= buf_full_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         byte_cnt_q   <= byte_cnt_d;
         hold_cnt_q   <= hold_cnt_d;
         wait_q       <= wait_d;
         dn_wr_q      <= dn_wr_d;
         dn_addr_q    <= dn_addr_d;
         dn_data_q    <= dn_data_d;
         core_reset_q <= core_reset_d;
         done_q       <= done_d;
         err_q        <= err_d;
         sum_q        <= sum_d;
      end
   end

   assign ioctl_wait = wait_q;
   assign dn_wr      = dn_wr_q;
   assign dn_addr    = dn_addr_q;
   assign dn_data    = dn_data_q;
   assign core_reset = core_reset_q;
   assign dl_done    = done_q;
   assign dl_err     = err_q;
   assign dl_sum     = sum_q;

endmodule
